inst_cache: RTL and testbench



---
 rtl/inst_cache.sv | 129 ++++++++++++
 tb/tb_inst_cache.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with burst line refill
// and hit/miss counters.
module inst_cache #(
   parameter int LINE_WORDS = 4,
   parameter int LINES      = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req_valid,
   input  logic [31:0] cpu_req_addr,
   output logic        cpu_req_ready,
   output logic        inst_valid,
   output logic [31:0] inst,
   input  logic        inv,
   output logic        mem_rd_req,
   output logic [31:0] mem_rd_addr,
   input  logic        mem_rd_ack,
   input  logic        mem_rd_dvalid,
   input  logic [31:0] mem_rd_data,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int WB  = $clog2(LINE_WORDS);
   localparam int OFF = WB + 2;
   localparam int IDX = $clog2(LINES);
   localparam int TW  = 32 - OFF - IDX;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_MISS   = 3'd2;
   localparam logic [2:0] S_REFILL = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   logic [2:0]       state;
   logic [31:2]      req_addr;
   logic [LINES-1:0] valid;
   logic [TW-1:0]    tag_mem  [LINES];
   logic [31:0]      data_mem [LINES][LINE_WORDS];
   logic [WB-1:0]    cnt;
   logic             pending;

   logic [WB-1:0]  req_off;
   logic [IDX-1:0] req_idx;
   logic [TW-1:0]  req_tag;
   logic           hit;
   logic           accept;
   logic           beat;
   logic           last_beat;
   logic           unused_addr_bits;

   assign unused_addr_bits = &{1'b0, cpu_req_addr[1:0]};

   assign req_off = req_addr[OFF-1:2];
   assign req_idx = req_addr[OFF+IDX-1:OFF];
   assign req_tag = req_addr[31:OFF+IDX];

   // The lookup reads the current valid bits, so an inv in this cycle only
   // affects later lookups.
   assign hit           = (state == S_LOOKUP) && valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign cpu_req_ready = (state == S_IDLE) || hit;
   assign accept        = cpu_req_valid && cpu_req_ready;
   assign inst_valid    = hit || (state == S_RESP);
   assign inst          = data_mem[req_idx][req_off];

   assign mem_rd_req  = (state == S_MISS);
   assign mem_rd_addr = mem_rd_req ? {req_addr[31:OFF], {OFF{1'b0}}} : 32'd0;

   assign beat      = (state == S_REFILL) && mem_rd_dvalid;
   assign last_beat = beat && (cnt == WB'(LINE_WORDS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         req_addr <= '0;
         valid    <= '0;
         pending  <= 1'b0;
         cnt      <= '0;
         hit_cnt  <= 32'd0;
         miss_cnt <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  req_addr <= cpu_req_addr[31:2];
                  state    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  hit_cnt <= hit_cnt + 32'd1;
                  if (accept) req_addr <= cpu_req_addr[31:2];
                  else        state    <= S_IDLE;
               end else begin
                  miss_cnt <= miss_cnt + 32'd1;
                  state    <= S_MISS;
               end
            end
            S_MISS: begin
               if (mem_rd_ack) begin
                  cnt   <= '0;
                  state <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (beat) begin
                  cnt <= cnt + 1'b1;
                  if (last_beat) state <= S_RESP;
               end
            end
            S_RESP: begin
               pending <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // An inv during a refill must keep the line in flight from becoming valid.
         if (inv && (state == S_MISS || state == S_REFILL)) pending <= 1'b1;

         if (inv)                        valid          <= '0;
         else if (last_beat && !pending) valid[req_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (beat)      data_mem[req_idx][cnt] <= mem_rd_data;
      if (last_beat) tag_mem[req_idx]       <= req_tag;
   end
endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - self-checking bench for inst_cache with a burst memory responder
// and a line-level reference model.
module tb_inst_cache;
   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req_valid;
   logic [31:0] cpu_req_addr;
   logic        cpu_req_ready;
   logic        inst_valid;
   logic [31:0] inst;
   logic        inv;
   logic        mem_rd_req;
   logic [31:0] mem_rd_addr;
   logic        mem_rd_ack;
   logic        mem_rd_dvalid;
   logic [31:0] mem_rd_data;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int compared   = 0;
   int mismatched = 0;

   int ack_delay    = 0;
   int beat_gap     = 0;
   int inv_at_beat  = -1;
   int inv_req      = 0;
   int inv_done     = 0;
   int req_seen     = 0;
   int req_unstable = 0;
   int beats_sent   = 0;
   logic [31:0] last_base = 32'd0;
   logic [31:0] mem [4096];

   inst_cache dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_req_valid (cpu_req_valid),
      .cpu_req_addr  (cpu_req_addr),
      .cpu_req_ready (cpu_req_ready),
      .inst_valid    (inst_valid),
      .inst          (inst),
      .inv           (inv),
      .mem_rd_req    (mem_rd_req),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_ack    (mem_rd_ack),
      .mem_rd_dvalid (mem_rd_dvalid),
      .mem_rd_data   (mem_rd_data),
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt)
   );

   always #5 clk = ~clk;

   // Memory side: acks after ack_delay cycles, then streams four beats separated
   // by beat_gap idle cycles; also issues inv pulses on request of the tests.
   initial begin
      int ms, bt, gap, dly, widx;
      logic [31:0] base;
      ms = 0; bt = 0; gap = 0; dly = 0; base = 32'd0;
      mem_rd_ack = 1'b0; mem_rd_dvalid = 1'b0; mem_rd_data = 32'd0; inv = 1'b0;
      forever begin
         @(negedge clk);
         mem_rd_ack = 1'b0; mem_rd_dvalid = 1'b0; inv = 1'b0;
         if (inv_done != inv_req) begin
            inv = 1'b1;
            inv_done = inv_req;
         end
         if (reset) begin
            ms = 0;
         end else if (ms == 0) begin
            if (mem_rd_req) begin
               base = mem_rd_addr; last_base = mem_rd_addr;
               req_seen++; dly = ack_delay; ms = 1;
            end
         end else if (ms == 2) begin
            if (cpu_req_ready) req_unstable++;
            if (bt == 4) ms = 0;
            else if (gap > 0) gap--;
            else begin
               widx = int'(base >> 2) + bt;
               mem_rd_dvalid = 1'b1;
               mem_rd_data = mem[widx[11:0]];
               if (bt == inv_at_beat) inv = 1'b1;
               bt++; beats_sent++; gap = beat_gap;
            end
         end
         if (!reset && ms == 1) begin
            if (!mem_rd_req || mem_rd_addr !== base || cpu_req_ready) req_unstable++;
            if (dly == 0) begin
               mem_rd_ack = 1'b1; ms = 2; bt = 0; gap = 0;
            end else dly--;
         end
      end
   end

   task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
      int t;
      t = 0;
      cpu_req_valid = 1'b1;
      cpu_req_addr  = a;
      while (!cpu_req_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      cpu_req_valid = 1'b0;
      lat = 1;
      while (!inst_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      d = inst;
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = 32'd0;
      #2;
      compared++;
      if ({cpu_req_ready, inst_valid, mem_rd_req} !== 3'b100) begin
         mismatched++;
         $display("FAIL reset_ctrl: got ready/ivalid/req=%b expected 100", {cpu_req_ready, inst_valid, mem_rd_req});
      end
      compared++;
      if ({mem_rd_addr, hit_cnt, miss_cnt} !== 96'd0) begin
         mismatched++;
         $display("FAIL reset_regs: got addr=%h hit=%0d miss=%0d expected all 0", mem_rd_addr, hit_cnt, miss_cnt);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cold_miss();
      logic [31:0] d;
      int lat, r0;
      ack_delay = 0; beat_gap = 0; r0 = req_seen;
      fetch(32'h40, d, lat);
      compared++;
      if (last_base !== 32'h40) begin
         mismatched++; $display("FAIL cold_addr: got %h expected 00000040", last_base);
      end
      compared++;
      if (lat !== 7) begin
         mismatched++; $display("FAIL cold_latency: got %0d expected 7", lat);
      end
      compared++;
      if (d !== 32'h11) begin
         mismatched++; $display("FAIL cold_data: got %h expected 00000011", d);
      end
      compared++;
      if (miss_cnt !== 32'd1 || req_seen !== r0 + 1) begin
         mismatched++; $display("FAIL cold_count: got miss=%0d bursts=%0d expected 1 and %0d", miss_cnt, req_seen, r0 + 1);
      end
   endtask

   task automatic test_back_to_back();
      int r0;
      @(negedge clk);
      r0 = req_seen;
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 32'h44;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compared++;
         if ({cpu_req_ready, inst_valid, inst} !== {2'b11, 32'h22 + 32'h11 * i}) begin
            mismatched++;
            $display("FAIL b2b_word%0d: got ready=%b valid=%b inst=%h expected 1 1 %h", i, cpu_req_ready, inst_valid, inst, 32'h22 + 32'h11 * i);
         end
         if (i < 2) cpu_req_addr = 32'h48 + 32'(4 * i);
         else       cpu_req_valid = 1'b0;
      end
      @(negedge clk);
      compared++;
      if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1 || req_seen !== r0) begin
         mismatched++;
         $display("FAIL b2b_counts: got hit=%0d miss=%0d bursts=%0d expected 3 1 %0d", hit_cnt, miss_cnt, req_seen, r0);
      end
   endtask

   task automatic test_conflict();
      logic [31:0] d;
      int lat;
      fetch(32'h440, d, lat);
      compared++;
      if (last_base !== 32'h440 || lat !== 7 || d !== mem[12'h110]) begin
         mismatched++;
         $display("FAIL conflict_fill: got addr=%h lat=%0d inst=%h expected 00000440 7 %h", last_base, lat, d, mem[12'h110]);
      end
      fetch(32'h40, d, lat);
      compared++;
      if (lat !== 7 || d !== 32'h11 || miss_cnt !== 32'd3) begin
         mismatched++;
         $display("FAIL conflict_refetch: got lat=%0d inst=%h miss=%0d expected 7 00000011 3", lat, d, miss_cnt);
      end
   endtask

   task automatic test_stall();
      logic [31:0] d;
      int lat, u0;
      ack_delay = 5; beat_gap = 1; u0 = req_unstable;
      fetch(32'hC8, d, lat);
      compared++;
      if (req_unstable !== u0 || last_base !== 32'hC0) begin
         mismatched++;
         $display("FAIL stall_handshake: got violations=%0d addr=%h expected %0d 000000c0", req_unstable, last_base, u0);
      end
      compared++;
      if (d !== mem[12'h32] || lat !== 15) begin
         mismatched++;
         $display("FAIL stall_word: got inst=%h lat=%0d expected %h 15", d, lat, mem[12'h32]);
      end
      ack_delay = 0; beat_gap = 0;
   endtask

   task automatic test_invalidate();
      logic [31:0] d;
      int lat, m0;
      m0 = miss_cnt;
      inv_at_beat = 1;
      fetch(32'h80, d, lat);
      inv_at_beat = -1;
      compared++;
      if (d !== mem[12'h20]) begin
         mismatched++; $display("FAIL inv_mid_word: got %h expected %h", d, mem[12'h20]);
      end
      fetch(32'h80, d, lat);
      compared++;
      if (lat !== 7 || miss_cnt !== m0 + 2 || d !== mem[12'h20]) begin
         mismatched++;
         $display("FAIL inv_mid_remiss: got lat=%0d miss=%0d inst=%h expected 7 %0d %h", lat, miss_cnt, d, m0 + 2, mem[12'h20]);
      end
      inv_at_beat = 3;
      fetch(32'h94, d, lat);
      inv_at_beat = -1;
      fetch(32'h94, d, lat);
      compared++;
      if (lat !== 7 || d !== mem[12'h25]) begin
         mismatched++;
         $display("FAIL inv_last_beat: got lat=%0d inst=%h expected 7 %h", lat, d, mem[12'h25]);
      end
   endtask

   task automatic test_reset_mid_refill();
      logic [31:0] d;
      int lat, b0, t;
      beat_gap = 2;
      @(negedge clk);
      b0 = beats_sent;
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 32'h100;
      @(negedge clk);
      cpu_req_valid = 1'b0;
      t = 0;
      while (beats_sent == b0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #2;
      compared++;
      if (cpu_req_ready !== 1'b0 || miss_cnt === 32'd0) begin
         mismatched++; $display("FAIL rst_pre: got ready=%b miss=%0d expected 0 and nonzero", cpu_req_ready, miss_cnt);
      end
      reset = 1'b1;
      #1;
      compared++;
      if ({cpu_req_ready, inst_valid, mem_rd_req, mem_rd_addr, hit_cnt, miss_cnt} !== {3'b100, 96'd0}) begin
         mismatched++;
         $display("FAIL rst_async: got ready=%b valid=%b req=%b addr=%h hit=%0d miss=%0d expected 1 0 0 0 0 0", cpu_req_ready, inst_valid, mem_rd_req, mem_rd_addr, hit_cnt, miss_cnt);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      beat_gap = 0;
      fetch(32'h100, d, lat);
      compared++;
      if (lat !== 7 || miss_cnt !== 32'd1 || hit_cnt !== 32'd0 || d !== mem[12'h40]) begin
         mismatched++;
         $display("FAIL rst_after: got lat=%0d miss=%0d hit=%0d inst=%h expected 7 1 0 %h", lat, miss_cnt, hit_cnt, d, mem[12'h40]);
      end
   endtask

   task automatic test_random();
      bit          mv [64];
      logic [21:0] mt [64];
      logic [31:0] a, d;
      logic [5:0]  idx;
      int lat, exp_lat, exp_h, exp_m;
      bit hit;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 64; i++) mv[i] = 1'b0;
      exp_h = 0; exp_m = 0;
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            repeat (2) @(negedge clk);
            inv_req++;
            repeat (3) @(negedge clk);
            for (int i = 0; i < 64; i++) mv[i] = 1'b0;
         end
         a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
         ack_delay = $urandom_range(0, 3);
         beat_gap  = $urandom_range(0, 2);
         idx = a[9:4];
         hit = mv[idx] && (mt[idx] == a[31:10]);
         exp_lat = hit ? 1 : 4 + ack_delay + 3 * (beat_gap + 1);
         fetch(a, d, lat);
         compared++;
         if (d !== mem[a[13:2]] || lat !== exp_lat) begin
            mismatched++;
            $display("FAIL rand_fetch%0d: addr=%h got inst=%h lat=%0d expected %h %0d", n, a, d, lat, mem[a[13:2]], exp_lat);
         end
         if (hit) exp_h++;
         else begin
            exp_m++;
            mv[idx] = 1'b1;
            mt[idx] = a[31:10];
         end
      end
      @(negedge clk);
      compared++;
      if (hit_cnt !== 32'(exp_h) || miss_cnt !== 32'(exp_m)) begin
         mismatched++;
         $display("FAIL rand_counts: got hit=%0d miss=%0d expected %0d %0d", hit_cnt, miss_cnt, exp_h, exp_m);
      end
      ack_delay = 0; beat_gap = 0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      mem[16] = 32'h11; mem[17] = 32'h22; mem[18] = 32'h33; mem[19] = 32'h44;
      test_reset();
      test_cold_miss();
      test_back_to_back();
      test_conflict();
      test_stall();
      test_invalidate();
      test_reset_mid_refill();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
